// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle multiply/divide unit for the EX stage, owner of HI/LO.
// MULT/MULTU take MUL_CYCLES cycles, DIV/DIVU take WIDTH+1 cycles
// (restoring radix-2 on magnitudes plus a sign-fix cycle).
// MTHI/MTLO write in a single cycle.
// Optional build macro MULDIV_EARLY_OUT_EN: divides by zero, or divides with
// |dividend| < |divisor|, skip the iteration phase and finish one cycle after accept.
module ex_muldiv #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   // state      | meaning
   // S_IDLE     | ready; accepts ops, MTHI/MTLO write here
   // S_MUL      | multiply in flight, counter runs down to 0
   // S_DIV_ITER | one restoring quotient bit per cycle, WIDTH cycles
   // S_DIV_FIX  | apply result signs (or divide-by-zero values), write HI/LO

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV_ITER, S_DIV_FIX} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;       // multiplicand, or raw dividend for div-by-zero
   logic [WIDTH-1:0]   b_q, b_d;       // multiplier, or divisor magnitude
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;   // dividend magnitude shifts out as quotient shifts in
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               sgn_q, sgn_d;
   logic               negq_q, negq_d;
   logic               negr_q, negr_d;
   logic               done_q, done_d;

   logic               accept;
   logic               rs_neg, rt_neg;
   logic [WIDTH-1:0]   rs_mag, rt_mag;
   logic               early;
   logic [2*WIDTH-1:0] ext_a, ext_b, prod;
   logic [WIDTH:0]     trial;

   assign accept = start & ~flush & (state_q == S_IDLE);
   assign rs_neg = (op == OP_DIV) & rs_val[WIDTH-1];
   assign rt_neg = (op == OP_DIV) & rt_val[WIDTH-1];
   assign rs_mag = rs_neg ? -rs_val : rs_val;
   assign rt_mag = rt_neg ? -rt_val : rt_val;

`ifdef MULDIV_EARLY_OUT_EN
   assign early = (rt_val == '0) || (rs_mag < rt_mag);
`else
   assign early = 1'b0;
`endif

   // Signed product comes from sign-extending both operands to 2*WIDTH.
   assign ext_a = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
   assign ext_b = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
   assign prod  = ext_a * ext_b;
   assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, b_q};

   // Next-state, datapath and HI/LO update logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      sgn_d   = sgn_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (op)
                  OP_MULT, OP_MULTU: begin
                     a_d     = rs_val;
                     b_d     = rt_val;
                     sgn_d   = (op == OP_MULT);
                     cnt_d   = CNT_W'(MUL_CYCLES - 1);
                     state_d = S_MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     a_d    = rs_val;
                     b_d    = rt_mag;
                     negq_d = rs_neg ^ rt_neg;
                     negr_d = rs_neg;
                     if (early) begin
                        rem_d   = rs_mag;
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = S_DIV_FIX;
                     end else begin
                        rem_d   = '0;
                        quo_d   = rs_mag;
                        cnt_d   = CNT_W'(WIDTH - 1);
                        state_d = S_DIV_ITER;
                     end
                  end
                  OP_MTHI: hi_d = rs_val;
                  OP_MTLO: lo_d = rs_val;
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            if (cnt_q == '0) begin
               hi_d    = prod[2*WIDTH-1:WIDTH];
               lo_d    = prod[WIDTH-1:0];
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DIV_ITER: begin
            if (!trial[WIDTH]) begin
               rem_d = trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) state_d = S_DIV_FIX;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         S_DIV_FIX: begin
            if (b_q == '0) begin
               lo_d = '1;
               hi_d = a_q;
            end else begin
               lo_d = negq_q ? -quo_q : quo_q;
               hi_d = negr_q ? -rem_q : rem_q;
            end
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Flush abandons the operation without touching HI/LO.
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
      end
   end

   // State and datapath registers, cleared by async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         sgn_q   <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         sgn_q   <= sgn_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vectors for ex_muldiv, a 32-bit/4-cycle instance
// and a 16-bit/2-cycle instance.
module tb_ex_muldiv;
   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;

   logic        start = 1'b0;
   logic [2:0]  op    = 3'd0;
   logic [31:0] rs    = '0;
   logic [31:0] rt    = '0;
   logic        flush = 1'b0;
   logic        busy, done;
   logic [31:0] hi, lo;

   logic        s_start = 1'b0;
   logic [2:0]  s_op    = 3'd0;
   logic [15:0] s_rs    = '0;
   logic [15:0] s_rt    = '0;
   logic        s_busy, s_done;
   logic [15:0] s_hi, s_lo;

   int n_total = 0;
   int n_bad   = 0;
   int lat, bcy, nd;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int EO_LAT = 1;
`else
   localparam int EO_LAT = 33;
`endif

   always #5 clk = ~clk;

   ex_muldiv #(.WIDTH(32), .MUL_CYCLES(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs), .rt_val(rt),
      .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   ex_muldiv #(.WIDTH(16), .MUL_CYCLES(2)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(s_start), .op(s_op), .rs_val(s_rs), .rt_val(s_rt),
      .flush(1'b0), .busy(s_busy), .done(s_done), .hi(s_hi), .lo(s_lo)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op for one cycle; returns just after the accept edge.
   task automatic issue(input bit w16, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      if (w16) begin
         s_start = 1'b1; s_op = o; s_rs = a[15:0]; s_rt = b[15:0];
      end else begin
         start = 1'b1; op = o; rs = a; rt = b;
      end
      tick();
      start = 1'b0; op = 3'd0; s_start = 1'b0; s_op = 3'd0;
   endtask

   // Counts edges after the accept edge until done is seen, and busy cycles before it.
   task automatic wait_done(input bit w16, output int l, output int bc);
      l  = 0;
      bc = 0;
      while (!(w16 ? s_done : done) && l < 200) begin
         if (w16 ? s_busy : busy) bc++;
         tick();
         l++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) tick();
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hi16", s_hi, 0);
      rst_n = 1'b1;
      tick();

      // MULT -2 * 3
      issue(0, 3'd1, 32'hFFFF_FFFE, 32'd3);
      wait_done(0, lat, bcy);
      chk("mult_lat", lat, 4);
      chk("mult_busy_cyc", bcy, 4);
      chk("mult_busy_at_done", busy, 0);
      chk("mult_hi", hi, 32'hFFFF_FFFF);
      chk("mult_lo", lo, 32'hFFFF_FFFA);
      tick();
      chk("mult_done_pulse", done, 0);

      // MULTU 0xFFFFFFFE * 3
      issue(0, 3'd2, 32'hFFFF_FFFE, 32'd3);
      wait_done(0, lat, bcy);
      chk("multu_lat", lat, 4);
      chk("multu_hi", hi, 32'h2);
      chk("multu_lo", lo, 32'hFFFF_FFFA);

      // DIV -7 / 2
      issue(0, 3'd3, 32'hFFFF_FFF9, 32'd2);
      wait_done(0, lat, bcy);
      chk("div_lat", lat, 33);
      chk("div_busy_cyc", bcy, 33);
      chk("div_lo", lo, 32'hFFFF_FFFD);
      chk("div_hi", hi, 32'hFFFF_FFFF);

      // DIV overflow
      issue(0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(0, lat, bcy);
      chk("divov_lo", lo, 32'h8000_0000);
      chk("divov_hi", hi, 32'h0);

      // DIVU by zero
      issue(0, 3'd4, 32'd5, 32'd0);
      wait_done(0, lat, bcy);
      chk("divz_lat", lat, EO_LAT);
      chk("divz_lo", lo, 32'hFFFF_FFFF);
      chk("divz_hi", hi, 32'd5);

      // DIV by zero with a negative dividend keeps the dividend in HI
      issue(0, 3'd3, 32'hFFFF_FFF9, 32'd0);
      wait_done(0, lat, bcy);
      chk("divzs_lo", lo, 32'hFFFF_FFFF);
      chk("divzs_hi", hi, 32'hFFFF_FFF9);

      // small dividend: 3 / -10 and -3 / 10
      issue(0, 3'd3, 32'd3, 32'hFFFF_FFF6);
      wait_done(0, lat, bcy);
      chk("divsm_lat", lat, EO_LAT);
      chk("divsm_lo", lo, 32'd0);
      chk("divsm_hi", hi, 32'd3);
      issue(0, 3'd3, 32'hFFFF_FFFD, 32'd10);
      wait_done(0, lat, bcy);
      chk("divsmn_lo", lo, 32'd0);
      chk("divsmn_hi", hi, 32'hFFFF_FFFD);

      // MTHI/MTLO then flush 3 cycles into a DIV
      issue(0, 3'd5, 32'h11, 32'd0);
      chk("mthi_hi", hi, 32'h11);
      chk("mthi_busy", busy, 0);
      issue(0, 3'd6, 32'h22, 32'd0);
      chk("mtlo_lo", lo, 32'h22);
      issue(0, 3'd3, 32'd100, 32'd7);
      tick();
      tick();
      flush = 1'b1; start = 1'b1; op = 3'd5; rs = 32'h99;
      tick();
      flush = 1'b0; start = 1'b0; op = 3'd0;
      chk("flush_busy", busy, 0);
      chk("flush_hi", hi, 32'h11);
      chk("flush_lo", lo, 32'h22);
      nd = 0;
      repeat (40) begin
         tick();
         if (done) nd++;
      end
      chk("flush_no_done", nd, 0);
      issue(0, 3'd6, 32'h55, 32'd0);
      chk("post_flush_mtlo", lo, 32'h55);
      chk("post_flush_hi", hi, 32'h11);

      // start held while busy, accepted in the done cycle
      start = 1'b1; op = 3'd2; rs = 32'd2; rt = 32'd3;
      tick();
      op = 3'd4; rs = 32'd100; rt = 32'd7;
      wait_done(0, lat, bcy);
      chk("hold_mul_lat", lat, 4);
      chk("hold_mul_lo", lo, 32'd6);
      chk("hold_mul_hi", hi, 32'd0);
      tick();
      start = 1'b0; op = 3'd0;
      chk("b2b_busy", busy, 1);
      wait_done(0, lat, bcy);
      chk("b2b_lat", lat, 33);
      chk("b2b_lo", lo, 32'd14);
      chk("b2b_hi", hi, 32'd2);

      // reset at iteration 10 of a DIV
      issue(0, 3'd3, 32'hFFFF_FFF9, 32'd2);
      repeat (10) tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_hi", hi, 0);
      chk("midrst_lo", lo, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      #2;
      rst_n = 1'b1;
      nd = 0;
      repeat (40) begin
         tick();
         if (done) nd++;
      end
      chk("midrst_no_done", nd, 0);

      // 16-bit instance
      issue(1, 3'd4, 32'h1234, 32'h10);
      wait_done(1, lat, bcy);
      chk("w16_div_lat", lat, 17);
      chk("w16_div_lo", s_lo, 16'h0123);
      chk("w16_div_hi", s_hi, 16'h0004);
      issue(1, 3'd1, 32'hFFFE, 32'h3);
      wait_done(1, lat, bcy);
      chk("w16_mult_lat", lat, 2);
      chk("w16_mult_hi", s_hi, 16'hFFFF);
      chk("w16_mult_lo", s_lo, 16'hFFFA);
      issue(1, 3'd2, 32'hFFFF, 32'hFFFF);
      wait_done(1, lat, bcy);
      chk("w16_multu_hi", s_hi, 16'hFFFE);
      chk("w16_multu_lo", s_lo, 16'h0001);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
